// File: rtl/phase_accumulator_bank.sv
// Multi-channel signed phase accumulator bank for the CORDIC vectoring datapath.
// Per-channel clear/load/add/sub with wrap or saturate, sticky overflow flags and a registered read port.
module phase_accumulator_bank #(
  parameter int WORD_LENGTH = 16,
  parameter int CHANNELS    = 4,
  parameter int CH_BITS     = 2,
  parameter int SATURATE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [CH_BITS-1:0]     wr_sel,
  input  logic                   load,
  input  logic                   acc,
  input  logic                   sub,
  input  logic [WORD_LENGTH-1:0] in,
  input  logic                   rd_en,
  input  logic [CH_BITS-1:0]     rd_sel,
  output logic [WORD_LENGTH-1:0] out,
  output logic                   out_valid,
  output logic [CHANNELS-1:0]    ovf,
  output logic                   sel_err
);

  localparam int W = WORD_LENGTH;
  localparam logic [CH_BITS:0] NCH = (CH_BITS+1)'(CHANNELS);

  logic [W-1:0] ch_q [CHANNELS];
  logic [W-1:0] wr_cur;
  logic [W-1:0] rd_data;
  logic [W:0]   sum;
  logic [W-1:0] acc_res;
  logic         acc_ovf;
  logic         wr_ok;
  logic         rd_ok;

  assign wr_ok = ({1'b0, wr_sel} < NCH);
  assign rd_ok = ({1'b0, rd_sel} < NCH);

  // Channel selection by explicit compare so out-of-range selects never index past the array.
  always_comb begin
    wr_cur  = '0;
    rd_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wr_sel == CH_BITS'(i)) wr_cur  = ch_q[i];
      if (rd_sel == CH_BITS'(i)) rd_data = ch_q[i];
    end
  end

  always_comb begin
    if (sub) sum = {wr_cur[W-1], wr_cur} - {in[W-1], in};
    else     sum = {wr_cur[W-1], wr_cur} + {in[W-1], in};
    acc_ovf = sum[W] ^ sum[W-1];
    acc_res = sum[W-1:0];
    if ((SATURATE != 0) && acc_ovf) begin
      // Sign bit of the widened sum gives the true direction of the overflow.
      if (sum[W]) acc_res = {1'b1, {(W-1){1'b0}}};
      else        acc_res = {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) ch_q[i] <= '0;
      ovf       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      out_valid <= rd_en;
      sel_err   <= ((load || acc) && !wr_ok) || (rd_en && !rd_ok);
      if (rd_en) out <= rd_ok ? rd_data : '0;

      if (clear) begin
        for (int unsigned i = 0; i < CHANNELS; i++) ch_q[i] <= '0;
        ovf <= '0;
      end else begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (wr_sel == CH_BITS'(i)) begin
            if (load) begin
              ch_q[i] <= in;
              ovf[i]  <= 1'b0;
            end else if (acc) begin
              ch_q[i] <= acc_res;
              if (acc_ovf) ovf[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_accumulator_bank.sv
// Self-checking bench: three bank configurations (wrap, saturate, 3-channel) driven in lockstep
// and compared against an integer-arithmetic reference model.
module tb_phase_accumulator_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0, load = 1'b0, acc = 1'b0, sub = 1'b0, rd_en = 1'b0;
  logic [1:0]  wr_sel = '0, rd_sel = '0;
  logic [15:0] din = '0;

  logic [15:0] dout [3];
  logic        dval [3];
  logic        derr [3];
  logic [3:0]  ovf_u0, ovf_u1;
  logic [2:0]  ovf_u2;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int          mch  [3][4];
  logic [3:0]  movf [3];
  logic [15:0] mout [3];
  logic        mval [3];
  logic        merr [3];
  int          nch  [3] = '{4, 4, 3};
  int          sat  [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  phase_accumulator_bank #(.WORD_LENGTH(16), .CHANNELS(4), .CH_BITS(2), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .wr_sel(wr_sel), .load(load), .acc(acc), .sub(sub),
    .in(din), .rd_en(rd_en), .rd_sel(rd_sel), .out(dout[0]), .out_valid(dval[0]),
    .ovf(ovf_u0), .sel_err(derr[0]));

  phase_accumulator_bank #(.WORD_LENGTH(16), .CHANNELS(4), .CH_BITS(2), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .wr_sel(wr_sel), .load(load), .acc(acc), .sub(sub),
    .in(din), .rd_en(rd_en), .rd_sel(rd_sel), .out(dout[1]), .out_valid(dval[1]),
    .ovf(ovf_u1), .sel_err(derr[1]));

  phase_accumulator_bank #(.WORD_LENGTH(16), .CHANNELS(3), .CH_BITS(2), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .wr_sel(wr_sel), .load(load), .acc(acc), .sub(sub),
    .in(din), .rd_en(rd_en), .rd_sel(rd_sel), .out(dout[2]), .out_valid(dval[2]),
    .ovf(ovf_u2), .sel_err(derr[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dut_ovf(input int k);
    if (k == 0) return ovf_u0;
    if (k == 1) return ovf_u1;
    return {1'b0, ovf_u2};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) mch[k][i] = 0;
      movf[k] = '0; mout[k] = '0; mval[k] = 1'b0; merr[k] = 1'b0;
    end
  endtask

  task automatic check_all(input string where);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_u%0d_out", where, k), 32'(dout[k]), 32'(mout[k]));
      check($sformatf("%s_u%0d_valid", where, k), 32'(dval[k]), 32'(mval[k]));
      check($sformatf("%s_u%0d_selerr", where, k), 32'(derr[k]), 32'(merr[k]));
      check($sformatf("%s_u%0d_ovf", where, k), 32'(dut_ovf(k)), 32'(movf[k]));
    end
  endtask

  // One clock of stimulus; the model evaluates the spec rules on the pre-edge state.
  task automatic step(input logic c, input logic l, input logic a, input logic s,
                      input logic [1:0] ws, input logic [15:0] d,
                      input logic re, input logic [1:0] rs, input string where);
    int r, n, inc;
    clear = c; load = l; acc = a; sub = s; wr_sel = ws; din = d; rd_en = re; rd_sel = rs;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      n = nch[k];
      merr[k] = ((l || a) && int'(ws) >= n) || (re && int'(rs) >= n);
      mval[k] = re;
      if (re) mout[k] = (int'(rs) < n) ? 16'(mch[k][rs]) : 16'h0000;
      if (c) begin
        for (int i = 0; i < 4; i++) mch[k][i] = 0;
        movf[k] = '0;
      end else if (int'(ws) < n) begin
        if (l) begin
          mch[k][ws] = int'($signed(d));
          movf[k][ws] = 1'b0;
        end else if (a) begin
          inc = int'($signed(d));
          r = s ? mch[k][ws] - inc : mch[k][ws] + inc;
          if (r > 32767 || r < -32768) begin
            movf[k][ws] = 1'b1;
            if (sat[k] != 0) r = (r > 32767) ? 32767 : -32768;
            else r = int'($signed(16'(r)));
          end
          mch[k][ws] = r;
        end
      end
    end
    #1;
    check_all(where);
  endtask

  task automatic ld(input logic [1:0] ch, input logic [15:0] v);
    step(0, 1, 0, 0, ch, v, 0, 0, "load");
  endtask

  task automatic ac(input logic [1:0] ch, input logic [15:0] v, input logic s);
    step(0, 0, 1, s, ch, v, 0, 0, "acc");
  endtask

  task automatic rd(input logic [1:0] ch);
    step(0, 0, 0, 0, 0, 16'h0, 1, ch, "read");
  endtask

  initial begin
    logic [15:0] rv;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // some activity, then an asynchronous reset mid-run
    ld(2'd1, 16'h1234);
    ac(2'd1, 16'h0100, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1, 2'd1, "pre_rst");
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      check("rst_read_u0", 32'(dout[0]), 32'h0);
    end
    check("rst_ovf_u0", 32'(ovf_u0), 32'h0);

    // load then accumulate
    ld(2'd2, 16'h1000);
    ac(2'd2, 16'h0800, 1'b0);
    ac(2'd2, 16'h0200, 1'b1);
    rd(2'd2);
    check("ldacc_ch2_u0", 32'(dout[0]), 32'h1600);
    rd(2'd0); rd(2'd1); rd(2'd3);

    // wrap overflow, sticky flag, cleared by load
    ld(2'd1, 16'h7F00);
    ac(2'd1, 16'h0200, 1'b0);
    rd(2'd1);
    check("wrap_ch1_u0", 32'(dout[0]), 32'h8100);
    check("wrap_ovf_u0", 32'(ovf_u0[1]), 32'h1);
    check("sat_ch1_u1", 32'(dout[1]), 32'h7FFF);
    ac(2'd1, 16'h0001, 1'b0);
    check("sticky_ovf_u0", 32'(ovf_u0[1]), 32'h1);
    ld(2'd1, 16'h0000);
    check("ovf_cleared_u0", 32'(ovf_u0[1]), 32'h0);

    // saturation boundaries
    ld(2'd0, 16'h8100);
    ac(2'd0, 16'h0200, 1'b1);
    rd(2'd0);
    check("sat_neg_u1", 32'(dout[1]), 32'h8000);
    check("sat_neg_ovf_u1", 32'(ovf_u1[0]), 32'h1);
    ld(2'd3, 16'h7FF0);
    ac(2'd3, 16'h0100, 1'b0);
    rd(2'd3);
    check("sat_pos_u1", 32'(dout[1]), 32'h7FFF);
    ld(2'd2, 16'h0000);
    ac(2'd2, 16'h8000, 1'b1);
    rd(2'd2);
    check("sub_minneg_u1", 32'(dout[1]), 32'h7FFF);
    check("sub_minneg_ovf_u1", 32'(ovf_u1[2]), 32'h1);
    check("sub_minneg_u0", 32'(dout[0]), 32'h8000);

    // simultaneous events
    step(0, 1, 1, 0, 2'd1, 16'h0123, 0, 0, "ld_and_acc");
    step(0, 0, 1, 0, 2'd1, 16'h0001, 1, 2'd1, "rd_and_acc");
    check("rd_old_u0", 32'(dout[0]), 32'h0123);
    rd(2'd1);
    check("rd_new_u0", 32'(dout[0]), 32'h0124);
    step(1, 1, 0, 0, 2'd1, 16'h5555, 1, 2'd1, "clr_ld_rd");
    check("clr_rd_pre_u0", 32'(dout[0]), 32'h0124);
    for (int i = 0; i < 4; i++) rd(2'(i));

    // select errors on the 3-channel bank
    ld(2'd0, 16'h0042);
    ac(2'd3, 16'h0100, 1'b0);
    check("wr_selerr_u2", 32'(derr[2]), 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, "idle");
    check("selerr_pulse_u2", 32'(derr[2]), 32'h0);
    rd(2'd3);
    check("rd_selerr_u2", 32'(derr[2]), 32'h1);
    check("rd_selerr_out_u2", 32'(dout[2]), 32'h0);
    check("rd_selerr_valid_u2", 32'(dval[2]), 32'h1);
    rd(2'd0);
    check("ch0_intact_u2", 32'(dout[2]), 32'h0042);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 3))
        0: rv = 16'($urandom);
        1: rv = 16'h8000;
        2: rv = 16'h7FFF;
        default: rv = 16'($urandom_range(0, 16'h0FFF));
      endcase
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 2'($urandom), rv, $urandom_range(0, 1) == 1,
           2'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_accumulator_bank.md
Name: phase_accumulator_bank

Overview:
- Multi-channel signed phase accumulator bank for the CORDIC vectoring datapath.
- Each channel holds one angle word. A channel can be cleared, loaded directly, or accumulated by adding or subtracting a per-iteration arctan increment.
- Up to CHANNELS vectors can be in flight in the CORDIC core; the core time-multiplexes them and uses this bank in place of single-word phase registers.
- Wrap and saturate overflow modes are supported, with per-channel sticky overflow flags and a registered read port.

Parameters:
- WORD_LENGTH, 16: angle word width; two's complement, full scale ±π.
- CHANNELS, 4: number of independent phase channels; must be 2 or more.
- CH_BITS, 2: width of channel-select fields; must satisfy 2^CH_BITS >= CHANNELS.
- SATURATE, 0: 0 = wrap on overflow (modular phase); 1 = clamp to the most-positive or most-negative word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all channels and all ovf flags.
- wr_sel  in  CH_BITS  target channel for load or accumulate.
- load  in  1  write `in` into channel wr_sel.
- acc  in  1  accumulate `in` into channel wr_sel.
- sub  in  1  when acc=1: 0 = add, 1 = subtract.
- in  in  WORD_LENGTH  load value or signed increment.
- rd_en  in  1  read request.
- rd_sel  in  CH_BITS  channel to read.
- out  out  WORD_LENGTH  registered read data.
- out_valid  out  1  qualifies out.
- ovf  out  CHANNELS  sticky overflow flag per channel.
- sel_err  out  1  one-cycle pulse on an out-of-range wr_sel or rd_sel.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): all channels, out, out_valid, ovf and sel_err go to 0. Reset asserted mid-operation discards any in-progress operation; the first edge after release behaves normally.
- Write priority per edge: clear > load > acc > hold.
  - clear affects every channel regardless of wr_sel.
  - load with acc in the same cycle: load wins and acc is ignored.
- load: channel[wr_sel] <= in; ovf[wr_sel] <= 0.
- acc arithmetic:
  - Compute r = channel ± in at WORD_LENGTH+1 bits, with both operands sign-extended.
  - Overflow occurs when r[W] != r[W-1].
  - SATURATE=0: result = r[W-1:0] (wraps).
  - SATURATE=1: on positive overflow result = 2^(W-1)-1; on negative overflow result = -2^(W-1).
  - Any overflow sets ovf[wr_sel], in either mode. The flag stays set until clear, load of that channel, or reset.
- Subtracting the most-negative word is valid; use the widened arithmetic above, not negate-then-add.
- wr_sel >= CHANNELS with load or acc asserted: no state change, sel_err pulses 1 on the next cycle.
- Read path, 1-cycle latency:
  - On an edge with rd_en=1: out <= channel[rd_sel], sampled pre-update. A same-cycle write to that channel is not visible until the following read.
  - out_valid <= rd_en.
  - When rd_en=0, out holds its last value and out_valid=0.
- rd_sel >= CHANNELS with rd_en=1: out <= 0, out_valid <= 1, sel_err pulses.
- clear with rd_en in the same cycle: the read returns the pre-clear value.
- Channels other than wr_sel are never modified except by clear or reset.
- Fully synchronous apart from rst; no combinational path from any input to any output.

Test Plan:
- Reset and read: assert rst=0 mid-run, then release; read ch0..ch3 → each read gives out=0x0000 with out_valid=1 exactly one cycle after rd_en, and ovf=4'b0000.
- Load then accumulate: load ch2=0x1000; acc add 0x0800; then acc sub 0x0200 → reading ch2 gives 0x1600. Channels 0, 1 and 3 remain 0.
- Wrap overflow (SATURATE=0): load ch1=0x7F00; acc add 0x0200 → ch1=0x8100 and ovf[1]=1. A later in-range acc leaves ovf[1]=1; load ch1 clears it.
- Saturate overflow (SATURATE=1):
  - load ch0=0x8100; acc sub 0x0200 → ch0=0x8000 and ovf[0]=1.
  - load ch3=0x7FF0; acc add 0x0100 → ch3=0x7FFF.
  - load ch2=0; acc sub 0x8000 → ch2=0x7FFF and ovf[2]=1.
- Simultaneous events:
  - load and acc together on ch1 with in=0x0123 → ch1=0x0123.
  - rd_en and acc on the same channel in one cycle → the read returns the old value; the next read returns the updated value.
  - clear together with load → all channels 0.
- Select error (CHANNELS=3, CH_BITS=2): acc with wr_sel=3 → no channel changes and sel_err pulses for one cycle. rd_en with rd_sel=3 → out=0, out_valid=1, and sel_err pulses.
